// File: rtl/pwm_multichannel_pkg.sv
// Shared definitions for the multichannel PWM generator.
package pwm_multichannel_pkg;

  localparam int unsigned PWM_MAX_CHANNELS = 16;
  localparam int unsigned PWM_MAX_WIDTH    = 16;

  // Count direction; only meaningful in the center-aligned build.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_multichannel_prescaler.sv
// Clock prescaler: one-cycle tick every PRESCALE clocks while en is high.
// Counting restarts from zero whenever en is low, so the first tick after
// enable arrives exactly PRESCALE clocks later.
module pwm_multichannel_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  // Divider count, wrapping at PRESCALE-1 and cleared while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (!en || (pcnt == LAST)) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  assign tick = en && (pcnt == LAST);

endmodule

// File: rtl/pwm_multichannel.sv
// N-channel PWM generator sharing one prescaler and one period counter.
// Period and duties are double-buffered: load captures into pending
// registers, which become active only at a period boundary (or every clock
// while disabled). Optional build macro PWM_CENTER_ALIGNED_EN selects an
// up/down (center-aligned) counter instead of the default sawtooth.
module pwm_multichannel
  import pwm_multichannel_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic                      load,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_tick,
  output logic [WIDTH-1:0]          cnt
);

  // Reject parameter values outside the supported range at elaboration.
  if ((CHANNELS < 1) || (CHANNELS > PWM_MAX_CHANNELS)) begin : g_bad_channels
    $error("pwm_multichannel: CHANNELS out of range");
  end
  if ((WIDTH < 2) || (WIDTH > PWM_MAX_WIDTH)) begin : g_bad_width
    $error("pwm_multichannel: WIDTH out of range");
  end

  logic                      tick;
  logic                      boundary_c;
  logic [WIDTH-1:0]          cnt_nxt;
  logic [WIDTH-1:0]          period_pend;
  logic [WIDTH-1:0]          period_act;
  logic [CHANNELS*WIDTH-1:0] duty_pend;
  logic [CHANNELS*WIDTH-1:0] duty_act;
  logic [CHANNELS-1:0]       cmp_c;

  pwm_multichannel_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  // Pending shadow registers; the last load before a boundary wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_pend <= '0;
      duty_pend   <= '0;
    end else if (load) begin
      period_pend <= period;
      duty_pend   <= duty_in;
    end
  end

`ifdef PWM_CENTER_ALIGNED_EN
  dir_e dir;
  dir_e dir_nxt;

  // Up/down counter; the boundary is the tick on which cnt returns to 0.
  always_comb begin
    cnt_nxt    = cnt;
    dir_nxt    = dir;
    boundary_c = 1'b0;
    if (tick) begin
      if (period_act == '0) begin
        boundary_c = 1'b1;
      end else if (dir == DIR_UP) begin
        if (cnt == period_act) begin
          dir_nxt = DIR_DOWN;
          cnt_nxt = cnt - WIDTH'(1);
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
      end else begin
        cnt_nxt = cnt - WIDTH'(1);
        if (cnt == WIDTH'(1)) begin
          boundary_c = 1'b1;
          dir_nxt    = DIR_UP;
        end
      end
    end
  end

  // Direction flag, forced up whenever the counter restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir <= DIR_UP;
    end else if (!en) begin
      dir <= DIR_UP;
    end else begin
      dir <= dir_nxt;
    end
  end
`else
  // Sawtooth counter; wrapping at period_act is the boundary.
  always_comb begin
    cnt_nxt    = cnt;
    boundary_c = 1'b0;
    if (tick) begin
      if (cnt == period_act) begin
        cnt_nxt    = '0;
        boundary_c = 1'b1;
      end else begin
        cnt_nxt = cnt + WIDTH'(1);
      end
    end
  end
`endif

  // Counter, boundary pulse and active-register reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      period_tick <= 1'b0;
      period_act  <= '0;
      duty_act    <= '0;
    end else if (!en) begin
      cnt         <= '0;
      period_tick <= 1'b0;
      period_act  <= period_pend;
      duty_act    <= duty_pend;
    end else begin
      cnt         <= cnt_nxt;
      period_tick <= boundary_c;
      if (boundary_c) begin
        period_act <= period_pend;
        duty_act   <= duty_pend;
      end
    end
  end

  // Per-channel compare against the shared counter.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_cmp
    assign cmp_c[i] = cnt < duty_act[i*WIDTH +: WIDTH];
  end

  // Registered outputs, held low while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= '0;
    end else if (!en) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= cmp_c;
    end
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench for pwm_multichannel: directed scenarios followed by
// randomized traffic, all compared every clock against a period-position
// reference model (clocks elapsed in the current period -> expected cnt).
module tb_pwm_multichannel;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned PS = 4;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          en      = 1'b0;
  logic          load    = 1'b0;
  logic [W-1:0]  period  = '0;
  logic [CH*W-1:0] duty_in = '0;
  logic [CH-1:0] pwm_out;
  logic          period_tick;
  logic [W-1:0]  cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_k;
  int m_act_p;
  int m_pend_p;
  int m_act_d  [CH];
  int m_pend_d [CH];
  logic [CH-1:0] e_pwm;
  logic          e_tick;
  int            e_cnt;

  always #5 clk = ~clk;

  pwm_multichannel #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .PRESCALE (PS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .period      (period),
    .duty_in     (duty_in),
    .load        (load),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .cnt         (cnt)
  );

  // Counter value after k clocks into a period with terminal value p.
  function automatic int cnt_of(input int k, input int p);
    int t;
    t = k / PS;
`ifdef PWM_CENTER_ALIGNED_EN
    if (p == 0) return 0;
    return (t <= p) ? t : (2 * p - t);
`else
    return t;
`endif
  endfunction

  // Period length in clocks.
  function automatic int len_of(input int p);
`ifdef PWM_CENTER_ALIGNED_EN
    return PS * ((p == 0) ? 1 : 2 * p);
`else
    return PS * (p + 1);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_k = 0;
    m_act_p = 0;
    m_pend_p = 0;
    for (int i = 0; i < CH; i++) begin
      m_act_d[i]  = 0;
      m_pend_d[i] = 0;
    end
    e_pwm = '0;
    e_tick = 1'b0;
    e_cnt = 0;
  endtask

  // One clock: advance model with the inputs seen at this edge, then compare.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < CH; i++)
      e_pwm[i] = en && (cnt_of(m_k, m_act_p) < m_act_d[i]);
    if (!en) begin
      m_k = 0;
      e_tick = 1'b0;
      m_act_p = m_pend_p;
      for (int i = 0; i < CH; i++) m_act_d[i] = m_pend_d[i];
    end else begin
      m_k++;
      e_tick = 1'b0;
      if (m_k == len_of(m_act_p)) begin
        m_k = 0;
        e_tick = 1'b1;
        m_act_p = m_pend_p;
        for (int i = 0; i < CH; i++) m_act_d[i] = m_pend_d[i];
      end
    end
    if (load) begin
      m_pend_p = int'(period);
      for (int i = 0; i < CH; i++) m_pend_d[i] = int'(duty_in[i*W +: W]);
    end
    e_cnt = cnt_of(m_k, m_act_p);
    #1;
    chk("cnt", 32'(cnt), 32'(e_cnt));
    chk("pwm_out", 32'(pwm_out), 32'(e_pwm));
    chk("period_tick", 32'(period_tick), 32'(e_tick));
  endtask

  task automatic do_load(input int p, input int d0, input int d1, input int d2, input int d3);
    period  = W'(p);
    duty_in = {W'(d3), W'(d2), W'(d1), W'(d0)};
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    for (int n = 0; n < 400; n++) begin
      if (period_tick) break;
      step();
    end
    chk(tag, 32'(period_tick), 32'd1);
  endtask

  int hi [CH];
  int nticks;
  int win;
  int exp_hi [CH];

  initial begin
    model_reset();
    #12;
    // Reset values
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_tick", 32'(period_tick), 32'd0);
    rst_n = 1'b1;

    // Basic pattern: period 9, duties 0/3/9/10
    en = 1'b0;
    do_load(9, 0, 3, 9, 10);
    step();
    en = 1'b1;
    wait_tick("first_boundary");
    win = len_of(9);
`ifdef PWM_CENTER_ALIGNED_EN
    exp_hi = '{0, 20, 68, 72};
`else
    exp_hi = '{0, 12, 36, 40};
`endif
    for (int i = 0; i < CH; i++) hi[i] = 0;
    nticks = 0;
    for (int n = 0; n < win; n++) begin
      step();
      for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
      nticks += int'(period_tick);
    end
    for (int i = 0; i < CH; i++) chk($sformatf("high_clks_ch%0d", i), 32'(hi[i]), 32'(exp_hi[i]));
    chk("ticks_per_window", 32'(nticks), 32'd1);

    // Mid-period duty change on ch1 (3 -> 7) at cnt=5
    for (int n = 0; n < 400; n++) begin
      if (cnt == W'(5)) break;
      step();
    end
    chk("reach_cnt5", 32'(cnt), 32'd5);
    do_load(9, 0, 7, 9, 10);
    for (int n = 0; n < 2 * win; n++) step();

    // Load on the boundary cycle itself
    wait_tick("sync_boundary");
    for (int n = 0; n < len_of(9) - 1; n++) step();
    do_load(9, 2, 4, 6, 8);
    for (int n = 0; n < 2 * win + 8; n++) step();

    // Two loads within one period: only the second is applied
    do_load(5, 1, 1, 1, 1);
    step(); step(); step();
    do_load(6, 2, 5, 7, 0);
    for (int n = 0; n < 3 * len_of(6); n++) step();

    // Enable low for 13 clocks with a load while disabled
    en = 1'b0;
    step(); step();
    do_load(4, 1, 2, 4, 5);
    for (int n = 0; n < 10; n++) step();
    en = 1'b1;
    for (int n = 0; n < 3 * len_of(4); n++) step();

    // Randomized traffic
    for (int n = 0; n < 1200; n++) begin
      en = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 9) == 0) begin
        period = W'($urandom_range(0, 12));
        for (int i = 0; i < CH; i++)
          duty_in[i*W +: W] = W'($urandom_range(0, int'(period) + 2));
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      step();
    end
    load = 1'b0;
    en = 1'b1;

    // Asynchronous reset mid-period
    for (int n = 0; n < 400; n++) begin
      if (cnt != '0) break;
      step();
    end
    chk("pre_reset_running", 32'(cnt != '0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_cnt", 32'(cnt), 32'd0);
    chk("async_rst_pwm", 32'(pwm_out), 32'd0);
    chk("async_rst_tick", 32'(period_tick), 32'd0);
    @(posedge clk);
    #1;
    chk("held_rst_cnt", 32'(cnt), 32'd0);
    #3;
    rst_n = 1'b1;
    do_load(3, 0, 1, 3, 4);
    for (int n = 0; n < 60; n++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
